// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared constants and types for the round-robin mux arbiter.
//   NUM_REQ      : number of requesters (A..D)
//   IDX_W        : width of a requester index
//   LOCK_MAX_DEF : default consecutive-grant limit for locked requesters
//   arb_state_t  : arbiter state (IDLE = no word held, XFER = word held)
// ---------------------------------------------------------------------------
package arb_pkg;

   localparam int NUM_REQ      = 4;
   localparam int IDX_W        = 2;
   localparam int LOCK_MAX_DEF = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } arb_state_t;

endpackage

// File: rtl/n_bit4x1Multiplexer.sv
// ---------------------------------------------------------------------------
// n_bit4x1Multiplexer
// Plain n-bit 4-to-1 multiplexer (shared datapath element).
//   A, B, C, D : n-bit data inputs
//   S          : 2-bit select (0=A, 1=B, 2=C, 3=D)
//   Y          : selected n-bit word (combinational)
// ---------------------------------------------------------------------------
module n_bit4x1Multiplexer #(
   parameter int n = 4
) (
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   input  logic [n-1:0] C,
   input  logic [n-1:0] D,
   input  logic [1:0]   S,
   output logic [n-1:0] Y
);

   // Select one of the four words
   always_comb begin
      Y = A;
      case (S)
         2'd0:    Y = A;
         2'd1:    Y = B;
         2'd2:    Y = C;
         2'd3:    Y = D;
         default: Y = A;
      endcase
   end

endmodule

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority encoder. Scans i_req starting at bit
// i_ptr, then i_ptr+1, ... modulo 4, and reports the first set bit.
//   i_req   : 4-bit request vector
//   i_ptr   : index holding highest priority
//   o_found : at least one request set
//   o_idx   : index of the winning request (0 when none)
// ---------------------------------------------------------------------------
module rr_priority_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic               o_found,
   output logic [IDX_W-1:0]   o_idx
);

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [NUM_REQ-1:0]   w_rot;
   logic [IDX_W-1:0]     w_off;

   // Rotate so that bit 0 of w_rot is the request at i_ptr
   assign w_dbl = {i_req, i_req} >> i_ptr;
   assign w_rot = w_dbl[NUM_REQ-1:0];

   // Fixed-priority encode of the rotated vector (lowest bit wins)
   always_comb begin
      o_found = 1'b1;
      w_off   = 2'd0;
      if (w_rot[0]) begin
         w_off = 2'd0;
      end else if (w_rot[1]) begin
         w_off = 2'd1;
      end else if (w_rot[2]) begin
         w_off = 2'd2;
      end else if (w_rot[3]) begin
         w_off = 2'd3;
      end else begin
         o_found = 1'b0;
         w_off   = 2'd0;
      end
   end

   // Undo the rotation; 2-bit add wraps D back to A
   assign o_idx = o_found ? (i_ptr + w_off) : 2'd0;

endmodule

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
// Round-robin arbiter sharing one n-bit 4x1 mux between requesters A..D.
// The granted word is captured into Y and held under VALID/READY.
//   CLK   : rising-edge clock
//   RST   : synchronous active-high reset
//   REQ   : request, bit0=A .. bit3=D
//   A..D  : requester data
//   LOCK  : per-requester lock request (only when ARB_LOCK_EN is defined)
//   READY : downstream accepts Y when VALID & READY
//   Y     : registered selected word
//   VALID : Y holds an untransferred word
//   GNT   : one-cycle one-hot pulse for the requester whose word was captured
//   S     : registered index of the last granted requester
// Optional feature macro: ARB_LOCK_EN (lock with LOCK_MAX grant limit).
// ---------------------------------------------------------------------------
module rr_mux_arbiter
   import arb_pkg::*;
#(
   parameter int n = 4
`ifdef ARB_LOCK_EN
   ,
   parameter int LOCK_MAX = LOCK_MAX_DEF
`endif
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_REQ-1:0] REQ,
   input  logic [n-1:0]       A,
   input  logic [n-1:0]       B,
   input  logic [n-1:0]       C,
   input  logic [n-1:0]       D,
`ifdef ARB_LOCK_EN
   input  logic [NUM_REQ-1:0] LOCK,
`endif
   input  logic               READY,
   output logic [n-1:0]       Y,
   output logic               VALID,
   output logic [NUM_REQ-1:0] GNT,
   output logic [IDX_W-1:0]   S
);

   arb_state_t         r_state;
   logic [n-1:0]       r_y;
   logic [NUM_REQ-1:0] r_gnt;
   logic [IDX_W-1:0]   r_s;
   logic [IDX_W-1:0]   r_ptr;

   logic               w_opp;
   logic [NUM_REQ-1:0] w_eff;
   logic               w_found;
   logic [IDX_W-1:0]   w_idx;
   logic [n-1:0]       w_mux;

   // An arbitration happens whenever no word is held or the held one leaves now
   assign w_opp = (r_state == ST_IDLE) || READY;

`ifdef ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   logic [CNT_W-1:0]   r_lock_cnt;
   logic               r_locked;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_keep;

   // A locked requester keeps its priority, so it is not masked in its GNT cycle
   assign w_eff = REQ & ~(r_gnt & {NUM_REQ{~r_locked}});

   // Consecutive-grant count for the candidate grant
   assign w_cnt_next = ((r_lock_cnt != {CNT_W{1'b0}}) && (w_idx == r_s)) ?
                       (r_lock_cnt + {{(CNT_W-1){1'b0}}, 1'b1}) :
                       {{(CNT_W-1){1'b0}}, 1'b1};

   // Keep the pointer on k while locked and under the grant limit
   assign w_keep = LOCK[w_idx] && (w_cnt_next < CNT_W'(LOCK_MAX));

   // Lock bookkeeping: counter restarts on a forced release or a new requester
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_lock_cnt <= {CNT_W{1'b0}};
         r_locked   <= 1'b0;
      end else if (w_opp && w_found) begin
         r_locked   <= w_keep;
         r_lock_cnt <= (w_cnt_next >= CNT_W'(LOCK_MAX)) ? {CNT_W{1'b0}} : w_cnt_next;
      end else begin
         r_lock_cnt <= r_lock_cnt;
         r_locked   <= r_locked;
      end
   end
`else
   // The requester just granted is ignored for one cycle
   assign w_eff = REQ & ~r_gnt;
`endif

   rr_priority_pick u_pick (
      .i_req   (w_eff),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

   n_bit4x1Multiplexer #(.n(n)) u_mux (
      .A (A),
      .B (B),
      .C (C),
      .D (D),
      .S (w_idx),
      .Y (w_mux)
   );

   // Arbiter FSM with registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_y     <= {n{1'b0}};
         r_gnt   <= {NUM_REQ{1'b0}};
         r_s     <= {IDX_W{1'b0}};
         r_ptr   <= {IDX_W{1'b0}};
      end else if (w_opp && w_found) begin
         r_state <= ST_XFER;
         r_y     <= w_mux;
         r_s     <= w_idx;
         r_gnt   <= 4'b0001 << w_idx;
`ifdef ARB_LOCK_EN
         r_ptr   <= w_keep ? w_idx : (w_idx + 2'd1);
`else
         r_ptr   <= w_idx + 2'd1;
`endif
      end else if (w_opp) begin
         // Nothing to grant: either stay idle or finish the held word
         r_state <= ST_IDLE;
         r_y     <= r_y;
         r_gnt   <= {NUM_REQ{1'b0}};
         r_s     <= r_s;
         r_ptr   <= r_ptr;
      end else begin
         // Backpressure: hold the word, grant pulse ends
         r_state <= r_state;
         r_y     <= r_y;
         r_gnt   <= {NUM_REQ{1'b0}};
         r_s     <= r_s;
         r_ptr   <= r_ptr;
      end
   end

   assign Y     = r_y;
   assign VALID = (r_state == ST_XFER);
   assign GNT   = r_gnt;
   assign S     = r_s;

endmodule
